inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: splices an immediate into a RISC-V style instruction template
// (I, S or B format) and delivers the result through a registered 2-entry FIFO
// with valid/ready handshakes on both sides.
// Optional feature macro: IMM_RANGE_CHECK_EN enables the immediate range check
// that drives ImmErr; without it ImmErr is constant 0.
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ImmSrc,
    input  logic [31:0]      Imm,
    input  logic [31:0]      Base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Inst,
    output logic             ImmErr,
    output logic [CNT_W-1:0] EncCount
);

    logic [31:0]      encInst;
    logic             encErr;
    logic [31:0]      instMem_q [2];
    logic [1:0]       errMem_q;
    logic             wrPtr_q;
    logic             rdPtr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             inReady_q;
    logic [CNT_W-1:0] encCount_q;
    logic             push;
    logic             pop;

    // Splice the immediate into the template; immediate-position Base bits are overwritten
    always_comb begin
        encInst = Base;
        unique case (ImmSrc)
            2'b00: begin
                encInst[31:20] = Imm[11:0];
            end
            2'b01: begin
                encInst[31:25] = Imm[11:5];
                encInst[11:7]  = Imm[4:0];
            end
            2'b10: begin
                encInst[31]    = Imm[12];
                encInst[30:25] = Imm[10:5];
                encInst[11:8]  = Imm[4:1];
                encInst[7]     = Imm[11];
            end
            default: begin
                encInst = Base;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that cannot survive truncation into the selected format
    always_comb begin
        encErr = 1'b0;
        unique case (ImmSrc)
            2'b00, 2'b01: begin
                encErr = !((&Imm[31:11]) || !(|Imm[31:11]));
            end
            2'b10: begin
                encErr = !((&Imm[31:12]) || !(|Imm[31:12])) || Imm[0];
            end
            default: begin
                encErr = 1'b1;
            end
        endcase
    end
`else
    logic unusedImmHigh;
    assign unusedImmHigh = ^Imm[31:13];
    assign encErr        = 1'b0;
`endif

    assign push = in_valid && inReady_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // FIFO storage, pointers, registered in_ready and the delivered-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            instMem_q[0] <= 32'h0;
            instMem_q[1] <= 32'h0;
            errMem_q     <= 2'b00;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            count_q      <= 2'd0;
            inReady_q    <= 1'b1;
            encCount_q   <= '0;
        end else begin
            if (push) begin
                instMem_q[wrPtr_q] <= encInst;
                errMem_q[wrPtr_q]  <= encErr;
                wrPtr_q            <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q    <= ~rdPtr_q;
                encCount_q <= encCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            count_q   <= count_d;
            inReady_q <= (count_d != 2'd2);
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (count_q != 2'd0);
    assign Inst      = instMem_q[rdPtr_q];
    assign ImmErr    = errMem_q[rdPtr_q];
    assign EncCount  = encCount_q;

endmodule
